// File: rtl/mem_dma.sv
// mem_dma: word-granular copy/fill DMA initiator on the system memory bus.
// Each word runs RD -> RGAP -> WR -> WGAP (fill skips the read half); the gaps let responders rearm.
module mem_dma #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_in,
  input  logic               fill_in,
  input  logic [31:0]        src_in,
  input  logic [31:0]        dst_in,
  input  logic [COUNT_W-1:0] count_in,
  input  logic [31:0]        fill_value_in,
  input  logic               abort_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [COUNT_W-1:0] remaining_out,
  output logic [31:0]        address_out,
  output logic               sel_out,
  output logic [3:0]         write_mask_out,
  output logic [31:0]        write_value_out,
  input  logic [31:0]        read_value_in,
  input  logic               ready_in
);

  typedef enum logic [2:0] {StIdle, StRd, StRgap, StWr, StWgap, StDone} state_e;

  state_e      state;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic        fill_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= StIdle;
      src_addr        <= '0;
      dst_addr        <= '0;
      fill_mode       <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      remaining_out   <= '0;
      address_out     <= '0;
      sel_out         <= 1'b0;
      write_mask_out  <= '0;
      write_value_out <= '0;
    end else begin
      done_out <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_in) begin
            src_addr      <= src_in & 32'hFFFF_FFFC;
            dst_addr      <= dst_in & 32'hFFFF_FFFC;
            fill_mode     <= fill_in;
            remaining_out <= count_in;
            busy_out      <= 1'b1;
            if (count_in == '0) begin
              // Empty job: pass through the idle gap so DONE follows with no bus activity.
              state <= StWgap;
            end else if (fill_in) begin
              state           <= StWr;
              sel_out         <= 1'b1;
              address_out     <= dst_in & 32'hFFFF_FFFC;
              write_mask_out  <= 4'b1111;
              write_value_out <= fill_value_in;
            end else begin
              state          <= StRd;
              sel_out        <= 1'b1;
              address_out    <= src_in & 32'hFFFF_FFFC;
              write_mask_out <= 4'b0000;
            end
          end
        end
        StRd: begin
          if (ready_in) begin
            write_value_out <= read_value_in;
            src_addr        <= src_addr + 32'd4;
            sel_out         <= 1'b0;
            state           <= StRgap;
          end
        end
        StRgap: begin
          state          <= StWr;
          sel_out        <= 1'b1;
          address_out    <= dst_addr;
          write_mask_out <= 4'b1111;
        end
        StWr: begin
          if (ready_in) begin
            dst_addr       <= dst_addr + 32'd4;
            remaining_out  <= remaining_out - COUNT_W'(1);
            sel_out        <= 1'b0;
            write_mask_out <= 4'b0000;
            state          <= StWgap;
          end
        end
        StWgap: begin
          // Abort is honoured only here, so a transfer in flight always finishes.
          if (remaining_out == '0 || abort_in) begin
            state    <= StDone;
            done_out <= 1'b1;
          end else if (fill_mode) begin
            state          <= StWr;
            sel_out        <= 1'b1;
            address_out    <= dst_addr;
            write_mask_out <= 4'b1111;
          end else begin
            state          <= StRd;
            sel_out        <= 1'b1;
            address_out    <= src_addr;
            write_mask_out <= 4'b0000;
          end
        end
        StDone: begin
          busy_out <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: RAM responder with configurable ready latency and a
// scoreboard of expected writes built from a memory model when each job is started.
module tb_mem_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in;
  logic        fill_in;
  logic [31:0] src_in;
  logic [31:0] dst_in;
  logic [15:0] count_in;
  logic [31:0] fill_value_in;
  logic        abort_in;
  logic        busy_out;
  logic        done_out;
  logic [15:0] remaining_out;
  logic [31:0] address_out;
  logic        sel_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;

  mem_dma #(.COUNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_in        (start_in),
    .fill_in         (fill_in),
    .src_in          (src_in),
    .dst_in          (dst_in),
    .count_in        (count_in),
    .fill_value_in   (fill_value_in),
    .abort_in        (abort_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .remaining_out   (remaining_out),
    .address_out     (address_out),
    .sel_out         (sel_out),
    .write_mask_out  (write_mask_out),
    .write_value_out (write_value_out),
    .read_value_in   (read_value_in),
    .ready_in        (ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wait_cycles = 1;
  int          sel_run = 0;
  int          sel_cycles = 0;
  logic [31:0] cap_addr, cap_val;
  logic [3:0]  cap_mask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: ready in the (wait_cycles+1)th cycle of a select, dropped on deselect.
  always @(negedge clk) begin
    if (reset || !sel_out) begin
      sel_run  = 0;
      ready_in = 1'b0;
    end else begin
      if (sel_run == 0) begin
        cap_addr = address_out;
        cap_mask = write_mask_out;
        cap_val  = write_value_out;
      end
      sel_run++;
      sel_cycles++;
      if (sel_run == wait_cycles + 1) begin
        ready_in = 1'b1;
        check("bus_addr_stable", address_out, cap_addr);
        check("bus_mask_stable", 32'(write_mask_out), 32'(cap_mask));
        check("bus_value_stable", write_value_out, cap_val);
        if (write_mask_out == 4'b1111) begin
          mem[address_out] = write_value_out;
          if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", address_out, e.addr);
            check("wr_data", write_value_out, e.data);
          end
        end else begin
          check("rd_mask", 32'(write_mask_out), 32'h0);
          read_value_in = mem_rd(address_out);
        end
      end
    end
  end

  task automatic run_dma(input string tag, input logic fill, input logic [31:0] src,
                         input logic [31:0] dst, input logic [31:0] fv, input int count,
                         input int n_wr, input int abort_rel, input int exp_lat,
                         input int exp_rem);
    logic [31:0] s, d;
    int          c0;
    bit          seen;
    wr_t         e;
    s = src & 32'hFFFF_FFFC;
    d = dst & 32'hFFFF_FFFC;
    for (int i = 0; i < n_wr; i++) begin
      e.addr = d + 32'(4 * i);
      e.data = fill ? fv : mem_rd(s + 32'(4 * i));
      exp_q.push_back(e);
    end
    @(negedge clk);
    start_in      = 1'b1;
    fill_in       = fill;
    src_in        = src;
    dst_in        = dst;
    count_in      = 16'(count);
    fill_value_in = fv;
    abort_in      = (abort_rel == 0);
    c0            = cyc;
    seen          = 1'b0;
    for (int t = 0; t < 2000 && !seen; t++) begin
      @(negedge clk);
      start_in = 1'b0;
      if (cyc - c0 == 1) check({tag, "_busy_rise"}, 32'(busy_out), 32'd1);
      if (abort_rel > 0 && cyc - c0 == abort_rel) abort_in = 1'b1;
      if (done_out) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(cyc - c0), 32'(exp_lat));
      check({tag, "_remaining"}, 32'(remaining_out), 32'(exp_rem));
      check({tag, "_busy_at_done"}, 32'(busy_out), 32'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done_out), 32'd0);
      check({tag, "_busy_fall"}, 32'(busy_out), 32'd0);
    end
    abort_in = 1'b0;
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_sel"}, 32'(sel_out), 32'd0);
    check({tag, "_mask"}, 32'(write_mask_out), 32'd0);
    check({tag, "_addr"}, address_out, 32'd0);
    check({tag, "_value"}, write_value_out, 32'd0);
    check({tag, "_busy"}, 32'(busy_out), 32'd0);
    check({tag, "_done"}, 32'(done_out), 32'd0);
    check({tag, "_remaining"}, 32'(remaining_out), 32'd0);
  endtask

  initial begin
    int  sel_before;
    bit  found;
    reset = 1'b1; start_in = 1'b0; fill_in = 1'b0; src_in = '0; dst_in = '0;
    count_in = '0; fill_value_in = '0; abort_in = 1'b0;
    read_value_in = '0; ready_in = 1'b0;
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'h11 * 32'(i + 1);
    for (int i = 0; i < 8; i++) mem[32'h300 + 32'(4 * i)] = 32'hA000_0000 + 32'(i);
    mem[32'h500] = 32'hCAFE_0001;
    mem[32'h504] = 32'hCAFE_0002;
    mem[32'h800] = 32'h1234_5678;
    mem[32'h804] = 32'h9ABC_DEF0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;

    run_dma("copy4", 1'b0, 32'h100, 32'h200, 32'h0, 4, 4, -1, 25, 0);
    for (int i = 0; i < 4; i++)
      check("copy4_src_kept", mem_rd(32'h100 + 32'(4 * i)), 32'h11 * 32'(i + 1));

    run_dma("fill3", 1'b1, 32'h0, 32'h0FF3, 32'hDEAD_BEEF, 3, 3, -1, 10, 0);

    sel_before = sel_cycles;
    run_dma("zero", 1'b0, 32'h100, 32'h200, 32'h0, 0, 0, -1, 2, 0);
    check("zero_no_sel", 32'(sel_cycles - sel_before), 32'd0);

    wait_cycles = 5;
    run_dma("stall", 1'b0, 32'h800, 32'h900, 32'h0, 2, 2, -1, 29, 0);
    wait_cycles = 0;
    run_dma("zerowait", 1'b1, 32'h0, 32'hA00, 32'h5A5A_A5A5, 2, 2, -1, 5, 0);
    wait_cycles = 1;

    run_dma("abort", 1'b0, 32'h300, 32'h400, 32'h0, 8, 2, 7, 13, 6);
    sel_before = sel_cycles;
    repeat (5) @(negedge clk);
    check("abort_no_sel_after", 32'(sel_cycles - sel_before), 32'd0);

    run_dma("abort_at_start", 1'b1, 32'h0, 32'hB00, 32'h0000_BEEF, 3, 1, 0, 4, 2);

    @(negedge clk);
    start_in = 1'b1; fill_in = 1'b0; src_in = 32'h100; dst_in = 32'h700; count_in = 16'd4;
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      start_in = 1'b0;
      if (sel_out && write_mask_out == 4'b1111) found = 1'b1;
    end
    check("rst_reach_wr", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_zero_outputs("rst_in_wr");
    reset = 1'b0;
    exp_q.delete();

    run_dma("wrap", 1'b0, 32'h500, 32'hFFFF_FFFC, 32'h0, 2, 2, -1, 13, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
